// File: rtl/mc_ctrl_if.sv
// Control bundle between the MCCPU main controller and its datapath.
interface mc_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite;
    logic [1:0] NPCOp;
    logic       IRWrite;
    logic       IorD;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] GPRSel;
    logic [1:0] WDSel;
    logic       EXTOp;
    logic       ALUSrcB;
    logic [2:0] ALUOp;
    logic       Illegal;

    modport master (
        input  Op, Funct, Zero,
        output PCWrite, NPCOp, IRWrite, IorD, MemWrite, RegWrite,
               GPRSel, WDSel, EXTOp, ALUSrcB, ALUOp, Illegal
    );

    modport slave (
        output Op, Funct, Zero,
        input  PCWrite, NPCOp, IRWrite, IorD, MemWrite, RegWrite,
               GPRSel, WDSel, EXTOp, ALUSrcB, ALUOp, Illegal
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle main control FSM for MCCPU: sequences fetch/decode/execute/memory/
// writeback and decodes datapath controls from the current state and Op/Funct.
module mc_ctrl (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    localparam logic [2:0] ALU_NOP  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_LUI  = 3'b111;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR,
        S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP
    } state_e;

    state_e state_q, state_d;

    logic [2:0] alu_sel;
    logic       alu_ok;
    logic       is_itype;

    logic       pc_write, ir_write, iord, mem_write, reg_write;
    logic       ext_op, alu_src_b, illegal;
    logic [1:0] npc_op, gpr_sel, wd_sel;
    logic [2:0] alu_op;

    // ALU-class decode; ALUWB reuses it since Op/Funct are held until FETCH
    always_comb begin
        alu_sel  = ALU_NOP;
        alu_ok   = 1'b0;
        is_itype = 1'b0;
        unique case (bus.Op)
            OP_R: begin
                alu_ok = 1'b1;
                unique case (bus.Funct)
                    6'b100000: alu_sel = ALU_ADD;
                    6'b100010: alu_sel = ALU_SUB;
                    6'b100100: alu_sel = ALU_AND;
                    6'b100101: alu_sel = ALU_OR;
                    6'b101010: alu_sel = ALU_SLT;
                    6'b101011: alu_sel = ALU_SLTU;
                    default:   alu_ok  = 1'b0;
                endcase
            end
            OP_ADDI: begin alu_sel = ALU_ADD; alu_ok = 1'b1; is_itype = 1'b1; end
            OP_ANDI: begin alu_sel = ALU_AND; alu_ok = 1'b1; is_itype = 1'b1; end
            OP_ORI:  begin alu_sel = ALU_OR;  alu_ok = 1'b1; is_itype = 1'b1; end
            OP_LUI:  begin alu_sel = ALU_LUI; alu_ok = 1'b1; is_itype = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        npc_op    = 2'b00;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        gpr_sel   = 2'b00;
        wd_sel    = 2'b00;
        ext_op    = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = ALU_NOP;
        illegal   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                if (bus.Op == OP_LW || bus.Op == OP_SW) state_d = S_MEMADR;
                else if (alu_ok)                       state_d = S_EXEC;
                else if (bus.Op == OP_BEQ)             state_d = S_BRANCH;
                else if (bus.Op == OP_J || bus.Op == OP_JAL) state_d = S_JUMP;
                else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_b = is_itype;
                ext_op    = (bus.Op == OP_ADDI);
                alu_op    = alu_sel;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                gpr_sel   = (bus.Op == OP_R) ? 2'b00 : 2'b01;
                alu_op    = alu_sel;
                state_d   = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_b = 1'b1;
                ext_op    = 1'b1;
                alu_op    = ALU_ADD;
                state_d   = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                gpr_sel   = 2'b01;
                wd_sel    = 2'b01;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_op   = ALU_SUB;
                ext_op   = 1'b1;
                npc_op   = 2'b01;
                pc_write = bus.Zero;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                npc_op   = 2'b10;
                if (bus.Op == OP_JAL) begin
                    reg_write = 1'b1;
                    gpr_sel   = 2'b10;
                    wd_sel    = 2'b10;
                end
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // reset masks every side effect, whatever state the register holds
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign bus.PCWrite  = pc_write;
    assign bus.NPCOp    = npc_op;
    assign bus.IRWrite  = ir_write;
    assign bus.IorD     = iord;
    assign bus.MemWrite = mem_write;
    assign bus.RegWrite = reg_write;
    assign bus.GPRSel   = gpr_sel;
    assign bus.WDSel    = wd_sel;
    assign bus.EXTOp    = ext_op;
    assign bus.ALUSrcB  = alu_src_b;
    assign bus.ALUOp    = alu_op;
    assign bus.Illegal  = illegal;
endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl against a per-instruction cycle schedule model.
module tb_mc_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {PCWrite,NPCOp,IRWrite,IorD,MemWrite,RegWrite,GPRSel,WDSel,EXTOp,ALUSrcB,ALUOp,Illegal}
    function automatic logic [16:0] observed();
        return {bus.PCWrite, bus.NPCOp, bus.IRWrite, bus.IorD, bus.MemWrite,
                bus.RegWrite, bus.GPRSel, bus.WDSel, bus.EXTOp, bus.ALUSrcB,
                bus.ALUOp, bus.Illegal};
    endfunction

    function automatic logic [4:0] enables();
        return {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.Illegal};
    endfunction

    // Expected outputs for cycle 'step' of instruction (op, fn); ncyc = its cycle count.
    function automatic logic [16:0] ref_out(input logic [5:0] op, input logic [5:0] fn,
                                            input int step, input logic zero, output int ncyc);
        logic       pcw = 0, irw = 0, iord = 0, mw = 0, rw = 0, ext = 0, srcb = 0, ill = 0;
        logic [1:0] npc = 0, gsel = 0, wsel = 0;
        logic [2:0] aop = 0, acode = 0;
        int kind = 0; // 0 illegal, 1 lw, 2 sw, 3 alu, 4 beq, 5 jump
        case (op)
            6'b000000: begin
                kind = 3;
                case (fn)
                    6'b100000: acode = 3'd1;
                    6'b100010: acode = 3'd2;
                    6'b100100: acode = 3'd3;
                    6'b100101: acode = 3'd4;
                    6'b101010: acode = 3'd5;
                    6'b101011: acode = 3'd6;
                    default:   kind  = 0;
                endcase
            end
            6'b100011: kind = 1;
            6'b101011: kind = 2;
            6'b000100: kind = 4;
            6'b001000: begin kind = 3; acode = 3'd1; end
            6'b001100: begin kind = 3; acode = 3'd3; end
            6'b001101: begin kind = 3; acode = 3'd4; end
            6'b001111: begin kind = 3; acode = 3'd7; end
            6'b000010, 6'b000011: kind = 5;
            default: kind = 0;
        endcase
        case (kind)
            1: ncyc = 5;
            2, 3: ncyc = 4;
            4, 5: ncyc = 3;
            default: ncyc = 2;
        endcase
        if (step == 0) begin
            pcw = 1; irw = 1;
        end else if (step == 1) begin
            ill = (kind == 0);
        end else if (step == 2) begin
            case (kind)
                1, 2: begin srcb = 1; ext = 1; aop = 3'd1; end
                3: begin srcb = (op != 6'b000000); ext = (op == 6'b001000); aop = acode; end
                4: begin aop = 3'd2; ext = 1; npc = 2'b01; pcw = zero; end
                5: begin
                    pcw = 1; npc = 2'b10;
                    if (op == 6'b000011) begin rw = 1; gsel = 2'b10; wsel = 2'b10; end
                end
                default: ;
            endcase
        end else if (step == 3) begin
            case (kind)
                1: iord = 1;
                2: begin iord = 1; mw = 1; end
                3: begin rw = 1; gsel = (op == 6'b000000) ? 2'b00 : 2'b01; aop = acode; end
                default: ;
            endcase
        end else if (step == 4 && kind == 1) begin
            rw = 1; gsel = 2'b01; wsel = 2'b01;
        end
        return {pcw, npc, irw, iord, mw, rw, gsel, wsel, ext, srcb, aop, ill};
    endfunction

    // Runs one instruction from its FETCH cycle; zmode 0/1 fixes Zero, 2 randomizes it.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int zmode, input int max_steps);
        int ncyc;
        logic [16:0] exp;
        void'(ref_out(op, fn, 0, 1'b0, ncyc));
        for (int s = 0; s < ncyc && s < max_steps; s++) begin
            @(negedge clk);
            if (s == 0) begin
                bus.Op    = op;
                bus.Funct = fn;
            end
            bus.Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            exp = ref_out(op, fn, s, bus.Zero, ncyc);
            check($sformatf("op%b_fn%b_s%0d", op, fn, s), 32'(observed()), 32'(exp));
        end
    endtask

    logic [5:0] ops [12];
    logic [5:0] fns [8];

    initial begin
        n_cmp = 0;
        n_err = 0;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001100,
                6'b001101, 6'b001111, 6'b000010, 6'b000011, 6'b000000, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b101010, 6'b101011, 6'b000000, 6'b111111};
        bus.Op    = 6'b100011;
        bus.Funct = 6'b000000;
        bus.Zero  = 1'b0;
        rst       = 1'b1;

        // reset held 3 cycles: no enables
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check($sformatf("reset_en_%0d", i), 32'(enables()), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // directed cases
        run_instr(6'b100011, 6'b000000, 0, 99);   // lw
        run_instr(6'b000000, 6'b100000, 0, 99);   // add
        run_instr(6'b000000, 6'b100010, 0, 99);   // sub
        run_instr(6'b000100, 6'b000000, 1, 99);   // beq taken
        run_instr(6'b000100, 6'b000000, 0, 99);   // beq not taken
        run_instr(6'b000011, 6'b000000, 0, 99);   // jal
        run_instr(6'b111111, 6'b000000, 0, 99);   // illegal op
        run_instr(6'b000000, 6'b111111, 0, 99);   // illegal funct

        // sw aborted by reset during MEMADR
        run_instr(6'b101011, 6'b000000, 0, 3);
        rst = 1'b1;
        #1;
        check("abort_memadr_en", 32'(enables()), 32'd0);
        @(negedge clk); #1;
        check("abort_rst_en", 32'(enables()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(6'b101011, 6'b000000, 0, 99);   // complete sw after abort

        // randomized instruction stream
        for (int k = 0; k < 150; k++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 11)];
            fn = fns[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
            run_instr(op, fn, 2, 99);
        end

        // final FETCH confirms the last instruction's length
        @(negedge clk); #1;
        check("final_fetch", 32'(observed()), 32'h12000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
